// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Purpose  : NZCV flag register with split write enables, ARM condition
//            evaluation with a per-instruction latched result (CondExQ), write
//            gating for PC/register/memory, and a DEPTH-entry flag save stack
//            for exception entry and return.
// Options  : COND_FLAG_BYPASS_EN - when defined, the condition is evaluated
//            against this cycle's next flag value instead of the registered one.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit #(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    Cond,
    input  logic [3:0]    ALUFlags,
    input  logic [1:0]    FlagW,
    input  logic          PCS,
    input  logic          NextPC,
    input  logic          RegW,
    input  logic          MemW,
    input  logic          CondLatch,
    input  logic          FlagPush,
    input  logic          FlagPop,
    output logic          PCWrite,
    output logic          RegWrite,
    output logic          MemWrite,
    output logic [3:0]    Flags,
    output logic          CondExQ,
    output logic [PW-1:0] StackDepth,
    output logic          StackFull,
    output logic          StackEmpty,
    output logic          StackErr
);

    localparam logic [PW-1:0] FULL_DEPTH = PW'(DEPTH);

    logic [3:0] stack_mem [DEPTH];
    logic [3:0] stack_top;
    logic [3:0] flags_next;
    logic [3:0] eval_flags;
    logic [1:0] flag_write;
    logic       cond_ex;
    logic       push_ok;
    logic       pop_ok;
    logic       stack_fault;

    assign StackFull  = (StackDepth == FULL_DEPTH);
    assign StackEmpty = (StackDepth == '0);

    // Push/pop qualification; simultaneous push and pop is a conflict and does neither
    always_comb begin
        push_ok     = FlagPush && !FlagPop && !StackFull;
        pop_ok      = FlagPop && !FlagPush && !StackEmpty;
        stack_fault = (FlagPush && FlagPop) || (FlagPush && StackFull) ||
                      (FlagPop && StackEmpty);
    end

    // Select the most recently pushed entry (index StackDepth-1)
    always_comb begin
        stack_top = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (StackDepth == PW'(i + 1)) begin
                stack_top = stack_mem[i];
            end
        end
    end

    // Gated flag write uses only the latched result, which keeps the path loop-free
    assign flag_write = FlagW & {2{CondExQ}};

    // Next flag value: a valid pop restores the saved flags, else split ALU writes
    always_comb begin
        flags_next = Flags;
        if (pop_ok) begin
            flags_next = stack_top;
        end else begin
            if (flag_write[1]) flags_next[3:2] = ALUFlags[3:2];
            if (flag_write[0]) flags_next[1:0] = ALUFlags[1:0];
        end
    end

`ifdef COND_FLAG_BYPASS_EN
    assign eval_flags = flags_next;
`else
    assign eval_flags = Flags;
`endif

    // Condition field decode against the selected flags {N,Z,C,V}
    always_comb begin
        case (Cond)
            4'b0000: cond_ex = eval_flags[2];
            4'b0001: cond_ex = !eval_flags[2];
            4'b0010: cond_ex = eval_flags[1];
            4'b0011: cond_ex = !eval_flags[1];
            4'b0100: cond_ex = eval_flags[3];
            4'b0101: cond_ex = !eval_flags[3];
            4'b0110: cond_ex = eval_flags[0];
            4'b0111: cond_ex = !eval_flags[0];
            4'b1000: cond_ex = eval_flags[1] && !eval_flags[2];
            4'b1001: cond_ex = !eval_flags[1] || eval_flags[2];
            4'b1010: cond_ex = (eval_flags[3] == eval_flags[0]);
            4'b1011: cond_ex = (eval_flags[3] != eval_flags[0]);
            4'b1100: cond_ex = !eval_flags[2] && (eval_flags[3] == eval_flags[0]);
            4'b1101: cond_ex = eval_flags[2] || (eval_flags[3] != eval_flags[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    // Write gating; register/memory writes are held off while reset is asserted
    always_comb begin
        RegWrite = RegW && CondExQ && !reset;
        MemWrite = MemW && CondExQ && !reset;
        PCWrite  = (PCS && CondExQ && !reset) || NextPC;
    end

    // Flags and latched condition result
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags   <= 4'b0000;
            CondExQ <= 1'b0;
        end else begin
            Flags <= flags_next;
            if (CondLatch) CondExQ <= cond_ex;
        end
    end

    // Flag save stack, its depth counter and the sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            StackDepth <= '0;
            StackErr   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= 4'b0000;
            end
        end else begin
            if (stack_fault) StackErr <= 1'b1;
            if (push_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (StackDepth == PW'(i)) stack_mem[i] <= Flags;
                end
                StackDepth <= StackDepth + 1'b1;
            end else if (pop_ok) begin
                StackDepth <= StackDepth - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_unit
// Purpose  : Directed self-checking bench for cond_unit (DEPTH=2).
//            Honours COND_FLAG_BYPASS_EN for the same-cycle latch case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, CondLatch, FlagPush, FlagPop;
    logic       PCWrite, RegWrite, MemWrite;
    logic [3:0] Flags;
    logic       CondExQ;
    logic [1:0] StackDepth;
    logic       StackFull, StackEmpty, StackErr;

    int tests  = 0;
    int failed = 0;

    cond_unit #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .CondLatch(CondLatch), .FlagPush(FlagPush), .FlagPop(FlagPop),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .CondExQ(CondExQ), .StackDepth(StackDepth),
        .StackFull(StackFull), .StackEmpty(StackEmpty), .StackErr(StackErr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        assert (act === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // ARM condition reference: base test chosen by Cond[3:1], inverted by Cond[0]
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf & ~z;
            3'd5: b = (n ~^ v);
            3'd6: b = ~z & (n ~^ v);
            default: b = 1'b1;
        endcase
        if (c[3:1] != 3'd7 && c[0]) b = ~b;
        return b;
    endfunction

    initial begin
        reset = 1'b1; Cond = 4'd0; ALUFlags = 4'd0; FlagW = 2'b00;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1;
        CondLatch = 1'b1; FlagPush = 1'b0; FlagPop = 1'b0;
        step(); step();
        // Behaviour while reset is held
        NextPC = 1'b1; PCS = 1'b1; #1;
        chk("rst_pcwrite", {7'd0, PCWrite}, 8'd1);
        chk("rst_regwrite", {7'd0, RegWrite}, 8'd0);
        chk("rst_memwrite", {7'd0, MemWrite}, 8'd0);
        chk("rst_flags", {4'd0, Flags}, 8'h0);
        chk("rst_condexq", {7'd0, CondExQ}, 8'd0);
        chk("rst_depth", {6'd0, StackDepth}, 8'd0);
        chk("rst_empty_full_err", {5'd0, StackEmpty, StackFull, StackErr}, 8'b100);
        NextPC = 1'b0; PCS = 1'b0;
        reset = 1'b0;

        // EQ with Z=0 fails
        Cond = 4'b0000; CondLatch = 1'b1; step();
        chk("eq_z0_condexq", {7'd0, CondExQ}, 8'd0);
        chk("eq_z0_regwrite", {7'd0, RegWrite}, 8'd0);
        // AL passes, then write N,Z
        Cond = 4'b1110; step();
        chk("al_condexq", {7'd0, CondExQ}, 8'd1);
        chk("al_regwrite", {7'd0, RegWrite}, 8'd1);
        chk("al_memwrite", {7'd0, MemWrite}, 8'd1);
        RegW = 1'b0; MemW = 1'b0;
        CondLatch = 1'b0; FlagW = 2'b10; ALUFlags = 4'b0100; step();
        chk("nz_write", {4'd0, Flags}, 8'h4);
        FlagW = 2'b00; Cond = 4'b0000; CondLatch = 1'b1; step();
        chk("eq_z1_condexq", {7'd0, CondExQ}, 8'd1);

        // Partial updates
        CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0000; step();
        chk("clear_flags", {4'd0, Flags}, 8'h0);
        FlagW = 2'b01; ALUFlags = 4'b1111; step();
        chk("cv_only", {4'd0, Flags}, 8'h3);
        FlagW = 2'b10; ALUFlags = 4'b0000; step();
        chk("nz_only", {4'd0, Flags}, 8'h3);

        // Same-cycle flag write and latch: Flags 0011 -> 0111, EQ
        FlagW = 2'b10; ALUFlags = 4'b0100; Cond = 4'b0000; CondLatch = 1'b1; step();
        chk("bypass_flags", {4'd0, Flags}, 8'h7);
`ifdef COND_FLAG_BYPASS_EN
        chk("bypass_condexq", {7'd0, CondExQ}, 8'd1);
`else
        chk("bypass_condexq", {7'd0, CondExQ}, 8'd0);
`endif

        // Full condition sweep
        for (int f = 0; f < 16; f++) begin
            FlagW = 2'b00; Cond = 4'b1110; CondLatch = 1'b1; step();
            FlagW = 2'b11; ALUFlags = 4'(f); CondLatch = 1'b0; step();
            chk("sweep_flags", {4'd0, Flags}, 8'(f));
            FlagW = 2'b00;
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c); CondLatch = 1'b1; step();
                chk($sformatf("cond_%0h_flags_%0h", c, f), {7'd0, CondExQ},
                    {7'd0, ref_cond(4'(c), 4'(f))});
            end
        end

        // NextPC overrides a failed condition (Flags=1111, NE fails)
        Cond = 4'b0001; CondLatch = 1'b1; step();
        chk("ne_fail", {7'd0, CondExQ}, 8'd0);
        CondLatch = 1'b0; PCS = 1'b1; #1;
        chk("pcs_gated", {7'd0, PCWrite}, 8'd0);
        NextPC = 1'b1; #1;
        chk("nextpc_force", {7'd0, PCWrite}, 8'd1);
        PCS = 1'b0; NextPC = 1'b0;

        // Stack: push 1010, push 0101, overflow
        Cond = 4'b1110; CondLatch = 1'b1; step();
        CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1010; step();
        FlagW = 2'b00; FlagPush = 1'b1; step();
        chk("push1_depth", {6'd0, StackDepth}, 8'd1);
        FlagPush = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0101; step();
        FlagW = 2'b00; FlagPush = 1'b1; step();
        chk("push2_depth", {6'd0, StackDepth}, 8'd2);
        chk("push2_full_err", {6'd0, StackFull, StackErr}, 8'b10);
        FlagW = 2'b11; ALUFlags = 4'b0000; step();
        chk("ovf_depth", {6'd0, StackDepth}, 8'd2);
        chk("ovf_full_err", {6'd0, StackFull, StackErr}, 8'b11);
        chk("ovf_flagwrite", {4'd0, Flags}, 8'h0);
        // Pop wins over a same-cycle flag write
        FlagPush = 1'b0; FlagPop = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111; step();
        chk("pop1_flags", {4'd0, Flags}, 8'h5);
        chk("pop1_depth", {6'd0, StackDepth}, 8'd1);
        FlagW = 2'b00; step();
        chk("pop2_flags", {4'd0, Flags}, 8'hA);
        chk("pop2_empty", {7'd0, StackEmpty}, 8'd1);
        step();
        chk("pop_empty_flags", {4'd0, Flags}, 8'hA);
        chk("pop_empty_depth", {6'd0, StackDepth}, 8'd0);
        FlagPop = 1'b0;

        // Underflow alone sets the error
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst2_err", {7'd0, StackErr}, 8'd0);
        FlagPop = 1'b1; step(); FlagPop = 1'b0;
        chk("udf_err", {7'd0, StackErr}, 8'd1);
        chk("udf_flags", {4'd0, Flags}, 8'h0);

        // Push/pop conflict alone sets the error, depth unchanged
        reset = 1'b1; step(); reset = 1'b0;
        FlagPush = 1'b1; step();
        chk("conf_pre_err", {6'd0, StackDepth, StackErr}, 8'b010);
        FlagPop = 1'b1; step();
        chk("conf_depth", {6'd0, StackDepth}, 8'd1);
        chk("conf_err", {7'd0, StackErr}, 8'd1);
        FlagPush = 1'b0; FlagPop = 1'b0;

        // Reset mid-instruction discards stack and latched result
        Cond = 4'b1110; CondLatch = 1'b1; step();
        reset = 1'b1; step(); reset = 1'b0; CondLatch = 1'b0;
        chk("rst3_state", {3'd0, CondExQ, StackDepth, StackErr, StackEmpty}, 8'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
